fword_frame_rx: RTL

//  Framed command decoder between spi_slaver and dds_addr. Consumes received SPI bytes (rxd_out/rxd_flag),

---
 rtl/fword_frame_pkg.sv | 20 ++
 rtl/edge_rise_det.sv | 21 ++
 rtl/fword_frame_rx.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fword_frame_pkg.sv
// Shared constants and state type for the framed FWORD command decoder.
package fword_frame_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] CMD_SET   = 8'h01;
   localparam logic [7:0] CMD_ADD   = 8'h02;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_CSUM    = 2'd1;
   localparam logic [1:0] ERR_CMD     = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   typedef enum logic [1:0] {
      StIdle,
      StCmd,
      StData,
      StCsum
   } state_e;

endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector: registers the flag and pulses for one cycle on a 0->1 transition.
module edge_rise_det (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic flag_i,
   output logic rise_o
);

   logic flag_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         flag_q <= 1'b0;
      end else begin
         flag_q <= flag_i;
      end
   end

   assign rise_o = flag_i & ~flag_q;

endmodule

// File: rtl/fword_frame_rx.sv
// Framed SPI command decoder: validates SYNC/CMD/XOR checksum and updates the DDS FWORD atomically.
module fword_frame_rx
   import fword_frame_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 3_000_000,
   parameter logic [31:0] FWORD_RST      = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rxd_flag,
   input  logic [7:0]  rxd_out,
   output logic [31:0] fword,
   output logic        fword_upd,
   output logic        frame_err,
   output logic [1:0]  err_code,
   output logic [7:0]  err_cnt,
   output logic [7:0]  txd_status,
   output logic        busy
);

   localparam int unsigned GapW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [GapW-1:0] GapMax = GapW'(TIMEOUT_CYCLES - 1);

   logic acc;

   edge_rise_det u_edge (
      .clk_i  (clk),
      .rst_ni (rst),
      .flag_i (rxd_flag),
      .rise_o (acc)
   );

   state_e          state_q, state_d;
   logic            add_q, add_d;
   logic [31:0]     data_q, data_d;
   logic [7:0]      csum_q, csum_d;
   logic [1:0]      idx_q, idx_d;
   logic [GapW-1:0] gap_q, gap_d;
   logic [31:0]     fword_q, fword_d;
   logic            upd_q, upd_d;
   logic            ferr_q, ferr_d;
   logic [1:0]      code_q, code_d;
   logic [7:0]      ecnt_q, ecnt_d;
   logic [3:0]      fcnt_q, fcnt_d;
   logic            ok_q, ok_d;
   logic            commit, abort;
   logic [1:0]      abort_code;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         add_q   <= 1'b0;
         data_q  <= '0;
         csum_q  <= '0;
         idx_q   <= '0;
         gap_q   <= '0;
         fword_q <= FWORD_RST;
         upd_q   <= 1'b0;
         ferr_q  <= 1'b0;
         code_q  <= ERR_NONE;
         ecnt_q  <= '0;
         fcnt_q  <= '0;
         ok_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         add_q   <= add_d;
         data_q  <= data_d;
         csum_q  <= csum_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         fword_q <= fword_d;
         upd_q   <= upd_d;
         ferr_q  <= ferr_d;
         code_q  <= code_d;
         ecnt_q  <= ecnt_d;
         fcnt_q  <= fcnt_d;
         ok_q    <= ok_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      add_d      = add_q;
      data_d     = data_q;
      csum_d     = csum_q;
      idx_d      = idx_q;
      fword_d    = fword_q;
      upd_d      = 1'b0;
      ferr_d     = 1'b0;
      code_d     = code_q;
      ecnt_d     = ecnt_q;
      fcnt_d     = fcnt_q;
      ok_d       = ok_q;
      commit     = 1'b0;
      abort      = 1'b0;
      abort_code = ERR_NONE;
      gap_d      = (state_q == StIdle || acc) ? '0 : gap_q + 1'b1;

      unique case (state_q)
         StIdle: begin
            if (acc && rxd_out == SYNC_BYTE) state_d = StCmd;
         end
         StCmd: begin
            if (acc) begin
               if (rxd_out == CMD_SET || rxd_out == CMD_ADD) begin
                  add_d   = (rxd_out == CMD_ADD);
                  csum_d  = rxd_out;
                  idx_d   = 2'd0;
                  state_d = StData;
               end else begin
                  abort      = 1'b1;
                  abort_code = ERR_CMD;
               end
            end
         end
         StData: begin
            if (acc) begin
               data_d[8*idx_q +: 8] = rxd_out;
               csum_d = csum_q ^ rxd_out;
               if (idx_q == 2'd3) state_d = StCsum;
               else               idx_d   = idx_q + 2'd1;
            end
         end
         StCsum: begin
            if (acc) begin
               if (rxd_out == csum_q) begin
                  commit = 1'b1;
               end else begin
                  abort      = 1'b1;
                  abort_code = ERR_CSUM;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // A byte arriving in the expiry cycle takes priority over the timeout.
      if (state_q != StIdle && !acc && gap_q == GapMax) begin
         abort      = 1'b1;
         abort_code = ERR_TIMEOUT;
      end

      if (commit) begin
         fword_d = add_q ? fword_q + data_q : data_q;
         upd_d   = 1'b1;
         ok_d    = 1'b1;
         fcnt_d  = fcnt_q + 4'd1;
         state_d = StIdle;
      end

      if (abort) begin
         state_d = StIdle;
         ferr_d  = 1'b1;
         code_d  = abort_code;
         ok_d    = 1'b0;
         if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
      end
   end

   assign fword      = fword_q;
   assign fword_upd  = upd_q;
   assign frame_err  = ferr_q;
   assign err_code   = code_q;
   assign err_cnt    = ecnt_q;
   assign txd_status = {ok_q, code_q, 1'b0, fcnt_q};
   assign busy       = (state_q != StIdle);

endmodule
